// File: rtl/exec_if.sv
`default_nettype none
// ============================================================================
// Module  : exec_if -- RS-to-execution-unit issue and CDB broadcast bundle
// Revision: 1.0
// ============================================================================
interface exec_if #(
    parameter int ROBID_BITS  = 7,
    parameter int VALUE_SIZE  = 32,
    parameter int OPCODE_SIZE = 20
);
    logic                             rdy_exc;
    logic [ROBID_BITS-1:0]            exc_robid;
    logic [VALUE_SIZE-1:0]            in_val1;
    logic [VALUE_SIZE-1:0]            in_val2;
    logic [OPCODE_SIZE-1:0]           in_opcode;
    logic                             robfull;
    logic                             exc_busy;
    logic                             exc_finish;
    logic [ROBID_BITS+VALUE_SIZE-1:0] CDB;
    logic                             exc_illegal;

    modport master (
        output rdy_exc, exc_robid, in_val1, in_val2, in_opcode, robfull,
        input  exc_busy, exc_finish, CDB, exc_illegal
    );

    modport slave (
        input  rdy_exc, exc_robid, in_val1, in_val2, in_opcode, robfull,
        output exc_busy, exc_finish, CDB, exc_illegal
    );
endinterface
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : exec_unit -- integer ALU/MUL, issue from RS, result onto the CDB
// Revision: 1.0
// ============================================================================
module exec_unit #(
    parameter int ROBID_BITS  = 7,
    parameter int VALUE_SIZE  = 32,
    parameter int OPCODE_SIZE = 20,
    parameter int MUL_LAT     = 4
) (
    input  logic   clk,
    input  logic   rst,
    exec_if.slave  bus
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_LAT - 1);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WAIT  = 2'd2,
        S_BCAST = 2'd3
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [CNT_W-1:0]                 r_cnt;
    logic [ROBID_BITS-1:0]            r_robid;
    logic [VALUE_SIZE-1:0]            r_val1;
    logic [VALUE_SIZE-1:0]            r_val2;
    logic [3:0]                       r_op;
    logic                             r_busy;
    logic                             r_finish;
    logic                             r_illegal;
    logic [ROBID_BITS+VALUE_SIZE-1:0] r_cdb;
    logic                             r_dup_valid;
    logic [ROBID_BITS-1:0]            r_dup_robid;

    logic                             w_dup;
    logic                             w_accept;
    logic                             w_bcast;
    logic [VALUE_SIZE-1:0]            w_result;
    logic                             w_illegal;
    logic                             w_unused_opcode;

    // Only the low nibble of the opcode is decoded.
    assign w_unused_opcode = ^bus.in_opcode[OPCODE_SIZE-1:4];

    // A re-presented tag that was just broadcast must not be executed twice.
    assign w_dup    = r_dup_valid && (bus.exc_robid == r_dup_robid);
    assign w_accept = bus.rdy_exc && !w_dup &&
                      ((r_state == S_IDLE) || (r_state == S_BCAST));

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (r_op)
            c_OP_ADD:  w_result = r_val1 + r_val2;
            c_OP_SUB:  w_result = r_val1 - r_val2;
            c_OP_AND:  w_result = r_val1 & r_val2;
            c_OP_OR:   w_result = r_val1 | r_val2;
            c_OP_XOR:  w_result = r_val1 ^ r_val2;
            c_OP_SLL:  w_result = r_val1 << r_val2[4:0];
            c_OP_SRL:  w_result = r_val1 >> r_val2[4:0];
            c_OP_SRA:  w_result = $signed(r_val1) >>> r_val2[4:0];
            c_OP_SLT:  w_result = VALUE_SIZE'($signed(r_val1) < $signed(r_val2));
            c_OP_SLTU: w_result = VALUE_SIZE'(r_val1 < r_val2);
            c_OP_MUL:  w_result = r_val1 * r_val2;
            default:   w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  if (r_cnt == '0) w_state_nxt = bus.robfull ? S_WAIT : S_BCAST;
            S_WAIT:  if (!bus.robfull) w_state_nxt = S_BCAST;
            S_BCAST: w_state_nxt = w_accept ? S_EXEC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_bcast = (w_state_nxt == S_BCAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_robid     <= '0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_op        <= '0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_illegal   <= 1'b0;
            r_cdb       <= '0;
            r_dup_valid <= 1'b0;
            r_dup_robid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= (w_state_nxt == S_EXEC) || (w_state_nxt == S_WAIT);
            r_finish <= w_bcast;

            if (w_accept) begin
                r_robid <= bus.exc_robid;
                r_val1  <= bus.in_val1;
                r_val2  <= bus.in_val2;
                r_op    <= bus.in_opcode[3:0];
                r_cnt   <= (bus.in_opcode[3:0] == c_OP_MUL) ? c_MUL_CNT : '0;
            end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // CDB is only ever rewritten by a broadcast; it holds otherwise.
            if (w_bcast) begin
                r_cdb       <= {r_robid, w_result};
                r_illegal   <= w_illegal;
                r_dup_robid <= r_robid;
                r_dup_valid <= 1'b1;
            end else begin
                r_illegal <= 1'b0;
                if (!bus.rdy_exc || (bus.exc_robid != r_dup_robid))
                    r_dup_valid <= 1'b0;
            end
        end
    end

    assign bus.exc_busy    = r_busy;
    assign bus.exc_finish  = r_finish;
    assign bus.CDB         = r_cdb;
    assign bus.exc_illegal = r_illegal;
endmodule
`default_nettype wire
